// File: rtl/seq_adder_pkg.sv
// Shared FSM state encoding and geometry helper for the chunk-serial adder.
package seq_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    typedef struct packed {
        int nchunk;
        int idx_w;
    } geom_t;

    // A single chunk still needs a one-bit index register.
    function automatic geom_t calc_geom(input int width, input int chunk);
        geom_t g;
        g.nchunk = width / chunk;
        g.idx_w  = (g.nchunk > 1) ? $clog2(g.nchunk) : 1;
        return g;
    endfunction

endpackage

// File: rtl/seq_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder made of one-bit full adders; also
// exposes the carry into its top bit for signed-overflow detection.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o,
    output logic             c_msb_o
);

    logic [CHUNK:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign co_o    = c[CHUNK];
    assign c_msb_o = c[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// Chunk-serial adder: one CHUNK-bit ripple adder reused for WIDTH/CHUNK cycles.
// Define SEQ_ADDER_SUB_EN to add a latched 'sub' input computing a - b.
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam geom_t GEOM   = calc_geom(WIDTH, CHUNK);
    localparam int    NCHUNK = GEOM.nchunk;
    localparam int    IDX_W  = GEOM.idx_w;

    localparam logic [IDX_W-1:0] LAST       = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

    if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("seq_adder: WIDTH must be an integer multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] a_q, b_q;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             accept;
    logic [31:0]      sh;
    logic [CHUNK-1:0] a_sl, b_sl, s_sl;
    logic             co_sl, cmsb_sl;

    // Subtraction is folded in at latch time as a + ~b + 1.
`ifdef SEQ_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign accept = (state_q == IDLE) && start;
    assign sh     = 32'(idx_q) * CHUNK;
    assign a_sl   = CHUNK'(a_q >> sh);
    assign b_sl   = CHUNK'(b_q >> sh);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i     (a_sl),
        .b_i     (b_sl),
        .c_i     (carry_q),
        .s_o     (s_sl),
        .co_o    (co_sl),
        .c_msb_o (cmsb_sl)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    carry_d = cin_eff;
                    sum_d   = '0;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~(SLICE_MASK << sh)) | (WIDTH'(s_sl) << sh);
                carry_d = co_sl;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = co_sl;
                    ovf_d   = co_sl ^ cmsb_sl;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operands only matter while RUN, which reset leaves, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b_eff;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder over four WIDTH/CHUNK configurations.
module tb_seq_adder;

    localparam int ND = 4;

    logic        clk;
    logic        reset;
    logic        start_v [ND];
    logic [31:0] a_v     [ND];
    logic [31:0] b_v     [ND];
    logic        cin_v   [ND];
`ifdef SEQ_ADDER_SUB_EN
    logic        sub_v   [ND];
`endif
    logic        busy_v  [ND];
    logic        done_v  [ND];
    logic        cout_v  [ND];
    logic        ovf_v   [ND];
    logic [15:0] sum0;
    logic [7:0]  sum1, sum2;
    logic [31:0] sum3;

    int n_checks = 0;
    int n_pass   = 0;

    seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub_v[0]),
`endif
        .a(a_v[0][15:0]), .b(b_v[0][15:0]), .cin(cin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0]));

    seq_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub_v[1]),
`endif
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1]));

    seq_adder #(.WIDTH(8), .CHUNK(8)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub_v[2]),
`endif
        .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2]));

    seq_adder #(.WIDTH(32), .CHUNK(4)) u_dut3 (
        .clk(clk), .reset(reset), .start(start_v[3]),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub_v[3]),
`endif
        .a(a_v[3]), .b(b_v[3]), .cin(cin_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .sum(sum3), .cout(cout_v[3]), .ovf(ovf_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int k);
        case (k)
            0:       return 16;
            1:       return 8;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int chunk_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int k);
        return (width_of(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << width_of(k)) - 32'd1);
    endfunction

    function automatic logic [31:0] sum_of(input int k);
        case (k)
            0:       return 32'(sum0);
            1:       return 32'(sum1);
            2:       return 32'(sum2);
            default: return sum3;
        endcase
    endfunction

    function automatic longint to_signed(input longint u, input int w);
        longint half = longint'(1) << (w - 1);
        return (u >= half) ? (u - 2 * half) : u;
    endfunction

    // Integer-arithmetic reference: a + b + cin, or a - b when sb is set.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb,
                         output logic [31:0] s, output logic co, output logic ov);
        longint m    = longint'(1) << w;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'({32'd0, a});
        longint ub   = longint'({32'd0, b});
        longint full, sfull;
        if (sb) begin
            full  = ua - ub;
            co    = (ua >= ub);
            sfull = to_signed(ua, w) - to_signed(ub, w);
        end else begin
            full  = ua + ub + longint'(ci);
            co    = (full >= m);
            sfull = to_signed(ua, w) + to_signed(ub, w) + longint'(ci);
        end
        s  = 32'(((full % m) + m) % m);
        ov = (sfull >= half) || (sfull < -half);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Runs one operation on DUT k from a posedge+1 slot and checks it against the model.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb, input string tag,
                          output logic [31:0] got_s, output logic got_co, output logic got_ov);
        int          edges;
        logic [31:0] es;
        logic        eco, eov;
        model(width_of(k), a, b, ci, sb, es, eco, eov);
        a_v[k]   = a;
        b_v[k]   = b;
        cin_v[k] = ci;
`ifdef SEQ_ADDER_SUB_EN
        sub_v[k] = sb;
`endif
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        a_v[k]   = $urandom & mask_of(k);
        b_v[k]   = $urandom & mask_of(k);
        cin_v[k] = ~ci;
`ifdef SEQ_ADDER_SUB_EN
        sub_v[k] = ~sb;
`endif
        chk({tag, "/busy"}, 64'(busy_v[k]), 64'd1);
        edges = 1;
        while (!done_v[k] && edges < 80) begin
            @(posedge clk); #1;
            edges++;
        end
        got_s  = sum_of(k);
        got_co = cout_v[k];
        got_ov = ovf_v[k];
        chk({tag, "/latency"}, 64'(edges), 64'(width_of(k) / chunk_of(k) + 1));
        chk({tag, "/sum"}, 64'(got_s), 64'(es));
        chk({tag, "/cout"}, 64'(got_co), 64'(eco));
        chk({tag, "/ovf"}, 64'(got_ov), 64'(eov));
        @(posedge clk); #1;
        chk({tag, "/done_once"}, {62'd0, done_v[k], busy_v[k]}, 64'd0);
        chk({tag, "/hold"}, 64'(sum_of(k)), 64'(es));
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tv[6];

    initial begin
        logic [31:0] gs;
        logic        gc, gv, sb_r;
        int          pulses;
        logic [31:0] pulse_sum;

        tv[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tv[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tv[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

        for (int k = 0; k < ND; k++) begin
            start_v[k] = 1'b0;
            a_v[k]     = 32'hFFFF_FFFF;
            b_v[k]     = 32'hFFFF_FFFF;
            cin_v[k]   = 1'b1;
`ifdef SEQ_ADDER_SUB_EN
            sub_v[k]   = 1'b0;
`endif
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("reset/dut%0d", k),
                {29'd0, busy_v[k], done_v[k], cout_v[k], ovf_v[k], sum_of(k)}, 64'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_op(0, 32'(tv[i].a), 32'(tv[i].b), tv[i].ci, 1'b0,
                   $sformatf("vec%0d", i), gs, gc, gv);
            chk($sformatf("vec%0d/tbl", i), {gs, 30'd0, gc, gv},
                {16'd0, tv[i].s, 30'd0, tv[i].co, tv[i].ov});
        end

        // Second start two edges into the run must be ignored.
        a_v[0] = 32'h1234; b_v[0] = 32'h4321; cin_v[0] = 1'b1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        a_v[0] = 32'hFFFF; b_v[0] = 32'hFFFF; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        pulses    = 0;
        pulse_sum = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (done_v[0]) begin
                pulses++;
                pulse_sum = sum_of(0);
            end
            @(posedge clk); #1;
        end
        chk("ignore/pulses", 64'(pulses), 64'd1);
        chk("ignore/sum", 64'(pulse_sum), 64'h5556);
        chk("ignore/idle", 64'(busy_v[0]), 64'd0);

        // Reset after two chunks aborts the run asynchronously.
        a_v[0] = 32'hAAAA; b_v[0] = 32'h1111; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort/partial", 64'(sum_of(0)), 64'h00BB);
        #2 reset = 1'b1;
        #1;
        chk("abort/async", {61'd0, busy_v[0], done_v[0], 1'b0}, 64'd0);
        chk("abort/sum", 64'(sum_of(0)), 64'd0);
        #2 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done_v[0] || busy_v[0]) pulses++;
        end
        chk("abort/no_done", 64'(pulses), 64'd0);
        run_op(0, 32'h1234, 32'h4321, 1'b1, 1'b0, "after_abort", gs, gc, gv);
        chk("after_abort/tbl", 64'(gs), 64'h5556);

`ifdef SEQ_ADDER_SUB_EN
        run_op(0, 32'h0005, 32'h0007, 1'b0, 1'b1, "sub0", gs, gc, gv);
        chk("sub0/tbl", {gs, 31'd0, gc}, {32'h0000_FFFE, 32'd0});
        run_op(0, 32'h8000, 32'h0001, 1'b1, 1'b1, "sub1", gs, gc, gv);
        chk("sub1/tbl", {gs, 31'd0, gv}, {32'h0000_7FFF, 32'd1});
`endif

        for (int k = 0; k < ND; k++) begin
            for (int n = 0; n < 15; n++) begin
                sb_r = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
                sb_r = 1'($urandom_range(0, 1));
`endif
                run_op(k, $urandom & mask_of(k), $urandom & mask_of(k),
                       1'($urandom_range(0, 1)), sb_r,
                       $sformatf("rand_d%0d_%0d", k, n), gs, gc, gv);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK (elaboration error otherwise).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, a request to begin an addition, sampled only in IDLE.
REQ-006 The block SHALL have port a, input, WIDTH, operand A, latched on an accepted start.
REQ-007 The block SHALL have port b, input, WIDTH, operand B, latched on an accepted start.
REQ-008 The block SHALL have port cin, input, 1, carry-in, latched on an accepted start.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port sum, output, WIDTH, the result.
REQ-012 The block SHALL have port cout, output, 1, the carry-out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1, signed two's-complement overflow.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL latch a, b and cin, clear the internal chunk index, and go to RUN.
REQ-016 In RUN, each edge SHALL add chunk i (bits i*CHUNK+CHUNK-1 down to i*CHUNK) with the registered carry, write that slice of sum, register the chunk carry, and increment i.
REQ-017 After chunk NCHUNK-1 (NCHUNK = WIDTH/CHUNK) the block SHALL go to DONE; done=1 for exactly that one cycle, then it SHALL return to IDLE.
REQ-018 Latency SHALL be NCHUNK+1 edges from start acceptance to done high; busy=1 in RUN only.
REQ-019 cout SHALL be the carry out of the final chunk; ovf SHALL equal (carry into MSB) XOR (carry out of MSB), both updated on the last RUN edge.
REQ-020 sum, cout and ovf SHALL hold their values after done until the next accepted start; on start the block SHALL clear sum to 0.
REQ-021 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-022 Changes on a, b or cin after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-023 On reset=1, the block SHALL go immediately to IDLE and force busy=0, done=0, sum=0, cout=0, ovf=0, and clear the chunk index and internal carry.
REQ-024 A reset mid-RUN SHALL abort the operation, with no done pulse afterwards.

Configuration
REQ-025 With macro SEQ_ADDER_SUB_EN defined, the block SHALL add an input port sub (1 bit, latched on start); when sub=1 it SHALL compute a + ~b + 1, with cin ignored, and cout=1 meaning no borrow.
REQ-026 Without SEQ_ADDER_SUB_EN, the sub port and its logic SHALL be absent and the block SHALL always compute a + b + cin.

Structure
REQ-027 Package seq_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and a function computing NCHUNK and the index width from WIDTH/CHUNK.
REQ-028 Sub-module chunk_adder SHALL be a combinational CHUNK-bit ripple adder built from one-bit full adders, outputting the sum slice, carry-out and carry into its MSB; it SHALL be instantiated once and reused each cycle.

Verification (WIDTH=16, CHUNK=4)
REQ-029 Test: a=0x1234, b=0x4321, cin=1 -> after 5 edges sum=0x5556, cout=0, ovf=0, done high for 1 cycle.
REQ-030 Test: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-031 Test: start pulsed again 2 edges after acceptance with different operands -> ignored; first result delivered unchanged and only one done pulse.
REQ-032 Test: reset asserted during RUN (after 2 chunks) -> busy, done and sum go to 0 asynchronously; no done pulse follows; the next start completes normally.
REQ-033 Test (SEQ_ADDER_SUB_EN): a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-034 Test: randomized WIDTH/CHUNK pairs (8/1, 8/8, 32/4) -> sum matches the reference model and latency = NCHUNK+1 edges.
